// File: rtl/alu_input_loader_if.sv
// alu_input_loader_if
// Groups the switch/button inputs and the ALU-facing outputs of the
// ALU input loader into one bundle.
//   i_sw        : slide-switch value sampled on each qualified press
//   i_btn       : raw buttons (0 = load A, 1 = load B, 2 = load OP)
//   o_aData     : operand A (signed)
//   o_bData     : operand B (signed)
//   o_operation : opcode
//   o_update    : one-cycle pulse on every cycle where something loaded
//   o_valid     : A, B and OP have all been loaded since reset
// master = the board/stimulus side, slave = the loader itself.
interface alu_input_loader_if #(
    parameter int NB_SW = 8,
    parameter int NB_AB = 8,
    parameter int NB_OP = 6
) ();

    logic        [NB_SW-1:0] i_sw;
    logic        [2:0]       i_btn;
    logic signed [NB_AB-1:0] o_aData;
    logic signed [NB_AB-1:0] o_bData;
    logic        [NB_OP-1:0] o_operation;
    logic                    o_update;
    logic                    o_valid;

    modport master (
        output i_sw,
        output i_btn,
        input  o_aData,
        input  o_bData,
        input  o_operation,
        input  o_update,
        input  o_valid
    );

    modport slave (
        input  i_sw,
        input  i_btn,
        output o_aData,
        output o_bData,
        output o_operation,
        output o_update,
        output o_valid
    );

endinterface

// File: rtl/alu_input_loader.sv
// alu_input_loader
// Debounces three push-buttons and, on each qualified press, copies the
// slide-switch value into operand A, operand B or the opcode register that
// feed the ALU. All outputs are registered and hold between presses.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : alu_input_loader_if.slave (switches, buttons, ALU outputs)
module alu_input_loader #(
    parameter int NB_SW     = 8,
    parameter int NB_AB     = 8,
    parameter int NB_OP     = 6,
    parameter int NB_DB     = 20,
    parameter int DB_CYCLES = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    alu_input_loader_if.slave  bus
);

    // Counter value at which a changed level has persisted DB_CYCLES edges.
    localparam logic [NB_DB-1:0] DB_TERM = NB_DB'(DB_CYCLES - 1);
    localparam logic [NB_DB-1:0] CNT_ONE = NB_DB'(1);

    logic [2:0] stable_s;
    logic [2:0] stable_d_s;
    logic [2:0] press_s;
    logic [2:0] loaded_next_s;

    logic signed [NB_AB-1:0] a_data_r;
    logic signed [NB_AB-1:0] b_data_r;
    logic        [NB_OP-1:0] operation_r;
    logic                    update_r;
    logic                    valid_r;
    logic        [2:0]       loaded_r;

    // Switch bits above the operand/opcode width are intentionally ignored.
    logic unused_sw_s;
    assign unused_sw_s = ^bus.i_sw;

    for (genvar k = 0; k < 3; k++) begin : g_ch
        logic             sync1_r;
        logic             sync2_r;
        logic             stable_r;
        logic             stable_d_r;
        logic [NB_DB-1:0] cnt_r;

        // Two-flop synchronizer for the asynchronous button level.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
            end else begin
                sync1_r <= bus.i_btn[k];
                sync2_r <= sync1_r;
            end
        end

        // Debounce: a new level must persist DB_CYCLES consecutive edges;
        // any return to the current stable level restarts qualification.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt_r    <= '0;
                stable_r <= 1'b0;
            end else if (sync2_r == stable_r) begin
                cnt_r    <= '0;
            end else if (cnt_r == DB_TERM) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r    <= cnt_r + CNT_ONE;
            end
        end

        // Delayed debounced level for rising-edge (press) detection.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                stable_d_r <= 1'b0;
            end else begin
                stable_d_r <= stable_r;
            end
        end

        assign stable_s[k]   = stable_r;
        assign stable_d_s[k] = stable_d_r;
    end

    // Press pulses and the loaded flags as they will be after this edge.
    always_comb begin
        press_s       = stable_s & ~stable_d_s;
        loaded_next_s = loaded_r | press_s;
    end

    // Load registers from the switches; every pressed channel uses the
    // same switch sample, and one update pulse covers all of them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_data_r    <= '0;
            b_data_r    <= '0;
            operation_r <= '0;
            update_r    <= 1'b0;
            valid_r     <= 1'b0;
            loaded_r    <= 3'b000;
        end else begin
            if (press_s[0]) begin
                a_data_r <= bus.i_sw[NB_AB-1:0];
            end
            if (press_s[1]) begin
                b_data_r <= bus.i_sw[NB_AB-1:0];
            end
            if (press_s[2]) begin
                operation_r <= bus.i_sw[NB_OP-1:0];
            end
            update_r <= |press_s;
            loaded_r <= loaded_next_s;
            valid_r  <= &loaded_next_s;
        end
    end

    assign bus.o_aData     = a_data_r;
    assign bus.o_bData     = b_data_r;
    assign bus.o_operation = operation_r;
    assign bus.o_update    = update_r;
    assign bus.o_valid     = valid_r;

endmodule

// File: tb/tb_alu_input_loader.sv
// tb_alu_input_loader
// Self-checking bench for alu_input_loader with DB_CYCLES=4, NB_DB=3.
// A reference model tracks the raw button samples in a sliding window and
// decides qualification from "the last DB_CYCLES synchronized samples all
// differ from the debounced level"; loads happen one edge after a rising
// debounced level.
module tb_alu_input_loader;

    localparam int NB_SW = 8;
    localparam int NB_AB = 8;
    localparam int NB_OP = 6;
    localparam int NB_DB = 3;
    localparam int DB    = 4;

    logic clock;
    logic reset;

    alu_input_loader_if #(.NB_SW(NB_SW), .NB_AB(NB_AB), .NB_OP(NB_OP)) bus ();

    alu_input_loader #(
        .NB_SW(NB_SW), .NB_AB(NB_AB), .NB_OP(NB_OP),
        .NB_DB(NB_DB), .DB_CYCLES(DB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2:0] hist[$];
    logic [2:0] m_stable;
    logic [2:0] m_pend;
    logic [2:0] m_loaded;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [5:0] m_op;
    logic       m_upd;
    logic       m_valid;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(3'b000);
        m_stable = 3'b000;
        m_pend   = 3'b000;
        m_loaded = 3'b000;
        m_a      = 8'h00;
        m_b      = 8'h00;
        m_op     = 6'h00;
        m_upd    = 1'b0;
        m_valid  = 1'b0;
    endtask

    task automatic model_edge();
        logic all_diff;
        if (reset) begin
            m_upd = |m_pend;
            if (m_pend[0]) m_a  = bus.i_sw[7:0];
            if (m_pend[1]) m_b  = bus.i_sw[7:0];
            if (m_pend[2]) m_op = bus.i_sw[5:0];
            m_loaded = m_loaded | m_pend;
            m_valid  = &m_loaded;
            m_pend   = 3'b000;
            // Newest raw sample; the synchronized view lags it by two edges.
            hist.push_back(bus.i_btn);
            for (int k = 0; k < 3; k++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= DB; j++) begin
                    if (hist[j][k] == m_stable[k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_stable[k] = ~m_stable[k];
                    if (m_stable[k]) m_pend[k] = 1'b1;
                end
            end
            void'(hist.pop_front());
        end
    endtask

    task automatic compare_all();
        check("aData",     int'(bus.o_aData),     int'($signed(m_a)));
        check("bData",     int'(bus.o_bData),     int'($signed(m_b)));
        check("operation", int'(bus.o_operation), int'(m_op));
        check("update",    int'(bus.o_update),    int'(m_upd));
        check("valid",     int'(bus.o_valid),     int'(m_valid));
    endtask

    // One clock edge: advance the model, then compare just after the edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [2:0] b, input logic [7:0] s, input int n);
        bus.i_btn = b;
        bus.i_sw  = s;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.i_btn = 3'b000;
        bus.i_sw  = 8'h00;
        reset     = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        #2;
        compare_all();
        @(posedge clock);
        #1 reset = 1'b1;

        // Single load A: visible exactly after edge 7, one update pulse.
        bus.i_sw  = 8'h0F;
        bus.i_btn = 3'b001;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) check("a_before_edge7", int'(bus.o_aData), 0);
            if (i == 7) begin
                check("a_edge7", int'(bus.o_aData), 15);
                check("upd_edge7", int'(bus.o_update), 1);
            end
            if (i == 8) check("upd_edge8", int'(bus.o_update), 0);
        end
        check("valid_after_a", int'(bus.o_valid), 0);
        hold(3'b000, 8'h0F, 8);

        // Bounce rejection on B, then a clean press.
        hold(3'b010, 8'h55, 3);
        hold(3'b000, 8'h55, 1);
        hold(3'b010, 8'h55, 3);
        hold(3'b000, 8'h55, 8);
        check("b_bounce", int'(bus.o_bData), 0);
        hold(3'b010, 8'h01, 8);
        check("b_clean", int'(bus.o_bData), 1);
        hold(3'b000, 8'h01, 8);

        // Simultaneous loads complete the set: valid rises with the update.
        bus.i_sw  = 8'h83;
        bus.i_btn = 3'b111;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 6) check("valid_pre", int'(bus.o_valid), 0);
            if (i == 7) begin
                check("sim_a", int'(bus.o_aData), -125);
                check("sim_b", int'(bus.o_bData), -125);
                check("sim_op", int'(bus.o_operation), 3);
                check("sim_upd", int'(bus.o_update), 1);
                check("sim_valid", int'(bus.o_valid), 1);
            end
            if (i == 8) check("sim_upd_once", int'(bus.o_update), 0);
        end
        hold(3'b000, 8'h83, 8);

        // Sign and width handling.
        hold(3'b001, 8'h8F, 8);
        hold(3'b000, 8'h8F, 8);
        check("a_signed", int'(bus.o_aData), -113);
        hold(3'b010, 8'h01, 8);
        hold(3'b000, 8'h01, 8);
        check("b_one", int'(bus.o_bData), 1);
        hold(3'b100, 8'hC3, 8);
        hold(3'b000, 8'hC3, 8);
        check("op_trunc", int'(bus.o_operation), 3);

        // Asynchronous reset clears nonzero outputs before any edge.
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_a", int'(bus.o_aData), 0);
        check("rst_b", int'(bus.o_bData), 0);
        check("rst_op", int'(bus.o_operation), 0);
        check("rst_upd", int'(bus.o_update), 0);
        check("rst_valid", int'(bus.o_valid), 0);
        step();
        reset = 1'b1;

        // Reset mid-debounce aborts; held button reloads 7 edges after release.
        hold(3'b001, 8'h55, 5);
        reset = 1'b0;
        #1;
        model_reset();
        step();
        step();
        check("abort_a", int'(bus.o_aData), 0);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) check("rel_a_edge6", int'(bus.o_aData), 0);
            if (i == 7) check("rel_a_edge7", int'(bus.o_aData), 85);
        end
        hold(3'b000, 8'h55, 8);

        // Randomized button activity with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 5) == 0) bus.i_btn[k] = ~bus.i_btn[k];
            end
            if ($urandom_range(0, 3) == 0) bus.i_sw = 8'($urandom);
            step();
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                compare_all();
                step();
                reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_input_loader.md
# alu_input_loader

Front-end stage that feeds the ALU operand and opcode inputs on the FPGA board. It debounces three push-buttons and latches the slide-switch value into operand A, operand B or the operation register on each debounced press. Its registered outputs drive the ALU's `i_Adata`, `i_Bdata` and `i_operation` directly and hold between presses.

## Interface
- `NB_SW`, 8: switch bus width; must be ≥ `NB_AB` and ≥ `NB_OP`.
- `NB_AB`, 8: operand width.
- `NB_OP`, 6: operation code width.
- `NB_DB`, 20: debounce counter width.
- `DB_CYCLES`, 1000000: consecutive cycles a changed button level must persist; 1 ≤ `DB_CYCLES` ≤ 2^`NB_DB`−1.

Ports:
- `clock`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_sw`  in  `NB_SW`  slide switches; asynchronous to `clock` but stable while a button is pressed.
- `i_btn`  in  3  raw buttons, active-high: bit 0 = load A, bit 1 = load B, bit 2 = load OP.
- `o_aData`  out  `NB_AB`  operand A to ALU, signed.
- `o_bData`  out  `NB_AB`  operand B to ALU, signed.
- `o_operation`  out  `NB_OP`  opcode to ALU.
- `o_update`  out  1  one-cycle pulse, one per cycle in which any register loaded.
- `o_valid`  out  1  high once A, B and OP have each been loaded since reset.

## Operation
- Per button, three identical channels, each with:
  - 2-flop synchronizer: `sync1` then `sync2`.
  - Debounced level `stable`.
  - Counter `cnt` of width `NB_DB`.
  - Delayed copy `stable_d`.
- Debounce rule on each edge:
  - If `sync2 == stable`: `cnt <= 0`.
  - Otherwise, if `cnt == DB_CYCLES−1`: `stable <= sync2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any bounce back to the `stable` level before terminal count clears `cnt` and restarts qualification.
- `stable_d <= stable` each edge. `press = stable & ~stable_d`, combinational, high one cycle.
- Press actions on the next edge:
  - press[0]: `o_aData <= i_sw[NB_AB-1:0]`.
  - press[1]: `o_bData <= i_sw[NB_AB-1:0]`.
  - press[2]: `o_operation <= i_sw[NB_OP-1:0]`.
- Release (falling `stable`) loads nothing.
- Simultaneous presses: every pressed channel loads in the same edge from the same `i_sw` sample. `o_update` pulses once.
- Per-channel `loaded` flags set on first press. `o_valid = &loaded`, registered, and stays high until reset.
- Switch bits above `NB_AB`/`NB_OP` are ignored. No sign extension: values are copied bit-for-bit.

## Timing
- Reset (`reset` = 0) asynchronously clears all state immediately, independent of `clock`:
  - `o_aData`, `o_bData`, `o_operation` = 0.
  - `o_update` = 0, `o_valid` = 0.
  - `sync*`, `stable`, `stable_d`, `cnt`, `loaded` = 0.
- Reset asserted mid-debounce or mid-press aborts the qualification. No load occurs.
- Latency: edge 1 is the first edge that samples `i_btn[k]` = 1. Then:
  - `sync2` = 1 after edge 2.
  - `stable` = 1 after edge `DB_CYCLES`+2.
  - Register and `o_update` change after edge `DB_CYCLES`+3.
  - `o_valid` rises on the same edge as the `o_update` of the last outstanding first load.
- Button held high through reset release behaves as a fresh press: it loads after `DB_CYCLES`+3 edges.
- Release qualification takes the same `DB_CYCLES`+2 edges. A new press can only qualify after the release has qualified.
- Outputs are constant except on load edges.

## Test plan
All scenarios use `DB_CYCLES`=4, `NB_DB`=3 and otherwise default parameters.
- **Reset values:** drive `reset`=0 with outputs previously nonzero -> all outputs 0 immediately, before any clock edge.
- **Single load A:** `i_sw`=8'h0F, `i_btn`=3'b001 held 10 cycles -> `o_aData`=8'h0F exactly after edge 7; `o_update` high for 1 cycle; `o_valid` stays 0.
- **Bounce rejection:** `i_btn[1]` toggles high 3 cycles, low 1, high 3, then low -> `o_bData` unchanged and no `o_update`. Then hold high 8 cycles with `i_sw`=8'h01 -> `o_bData`=8'h01.
- **Simultaneous loads:** `i_sw`=8'h83, `i_btn`=3'b111 held -> `o_aData`=`o_bData`=8'h83 and `o_operation`=6'b000011 on the same edge; a single 1-cycle `o_update`; `o_valid`=1 on that edge.
- **Sign and width:** `i_sw`=8'h8F on A, then 8'h01 on B -> `o_aData` reads −113 signed, `o_bData`=1. `i_sw`=8'hC3 on OP -> `o_operation`=6'h03.
- **Reset mid-debounce:** press A and assert `reset` after edge 5 -> no load. Release `reset` with the button still held -> `o_aData` loads 7 edges after release.
